// File: rtl/dac_write_arbiter.sv
// -----------------------------------------------------------------------------
// dac_write_arbiter
//   Shares one DAC SPI serializer between DAC channels A (0) and B (1).
//   Picks a winner round-robin, builds the 16-bit DAC command word, launches
//   the serializer, waits for completion (with timeout), then enforces a
//   minimum idle gap before the next arbitration.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active low
//   req[1:0]   : per-channel request, held by the source until ack
//   data0/1    : channel A/B sample
//   ack[1:0]   : one-cycle grant pulse, coincident with ser_start
//   ser_start  : one-cycle serializer launch pulse
//   ser_word   : command {ch, BUF, GAIN_N, SHDN_N, sample[11:0]}
//   ser_busy   : serializer busy, blocks arbitration
//   ser_done   : one-cycle end-of-frame pulse from the serializer
//   grant_id   : channel of current / last frame
//   busy       : block not idle
//   err        : sticky timeout flag
// -----------------------------------------------------------------------------
module dac_write_arbiter #(
    parameter int   DATA_W     = 12,
    parameter int   MIN_GAP    = 2,
    parameter int   TIMEOUT    = 64,
    parameter logic BUF_BIT    = 1'b0,
    parameter logic GAIN_N_BIT = 1'b1,
    parameter logic SHDN_N_BIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        ack,
    output logic              ser_start,
    output logic [15:0]       ser_word,
    input  logic              ser_busy,
    input  logic              ser_done,
    output logic              grant_id,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;       // last granted channel
    logic            gid_q, gid_d;
    logic [15:0]     word_q, word_d;
    logic            start_q, start_d;
    logic [1:0]      ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;

    logic            win;
    logic [11:0]     samp;
    logic            finish;

    // With both requesting, the channel not granted last wins.
    assign win  = (req == 2'b11) ? ~ptr_q : req[1];
    assign samp = win ? 12'(data1) : 12'(data0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        word_d  = word_q;
        start_d = 1'b0;
        ack_d   = 2'b00;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        finish  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00 && !ser_busy) begin
                    start_d = 1'b1;
                    ack_d   = win ? 2'b10 : 2'b01;
                    gid_d   = win;
                    word_d  = {win, BUF_BIT, GAIN_N_BIT, SHDN_N_BIT, samp};
                    ptr_d   = win;
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // start_q marks the first WAIT cycle, where ser_done is not yet
                // honoured. A done coinciding with the timeout wins over it.
                if (ser_done && !start_q) begin
                    finish = 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
                if (finish) begin
                    if (MIN_GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = GW'(MIN_GAP);
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q <= GW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;        // so channel A wins the first tie
            gid_q   <= 1'b0;
            word_q  <= '0;
            start_q <= 1'b0;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            word_q  <= word_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign ack       = ack_q;
    assign ser_start = start_q;
    assign ser_word  = word_q;
    assign grant_id  = gid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dac_write_arbiter
//   Two instances share random stimulus: u0 with defaults (MIN_GAP=2,
//   TIMEOUT=64) and u1 with MIN_GAP=0, TIMEOUT=5. Each is compared every cycle
//   against a frame-timing model: a frame starting at cycle s ends at the
//   first done after s or at s+TIMEOUT-1, and arbitration reopens MIN_GAP+1
//   cycles after the end.
// -----------------------------------------------------------------------------
module tb_dac_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [11:0] data0, data1;
    logic        ser_busy, ser_done;

    logic [1:0]  ack0, ack1;
    logic        st0, st1;
    logic [15:0] word0, word1;
    logic        gid0, gid1, busy0, busy1, err0, err1;

    always #5 clk = ~clk;

    dac_write_arbiter u0 (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .ack(ack0), .ser_start(st0), .ser_word(word0), .ser_busy(ser_busy),
        .ser_done(ser_done), .grant_id(gid0), .busy(busy0), .err(err0)
    );

    dac_write_arbiter #(.MIN_GAP(0), .TIMEOUT(5)) u1 (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .ack(ack1), .ser_start(st1), .ser_word(word1), .ser_busy(ser_busy),
        .ser_done(ser_done), .grant_id(gid1), .busy(busy1), .err(err1)
    );

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // model state per instance
    bit          act [2];
    int          st  [2];
    int          ok  [2];
    int          ptr [2];
    bit          e_start [2];
    logic [1:0]  e_ack   [2];
    logic [15:0] e_word  [2];
    bit          e_gid   [2];
    bit          e_busy  [2];
    bit          e_err   [2];
    int          n_frames [2];
    int          n_tmo    [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_step(input int k, input int tmo, input int gap);
        int g;
        if (!rst) begin
            act[k] = 0; ok[k] = 0; ptr[k] = 1;
            e_start[k] = 0; e_ack[k] = 0; e_word[k] = 0;
            e_gid[k] = 0; e_err[k] = 0; e_busy[k] = 0;
            return;
        end
        e_start[k] = 0;
        e_ack[k]   = 0;
        if (act[k]) begin
            if (ser_done && t > st[k]) begin
                act[k] = 0;
                ok[k]  = t + gap + 1;
            end else if (t - st[k] + 1 == tmo) begin
                act[k]   = 0;
                e_err[k] = 1;
                ok[k]    = t + gap + 1;
                n_tmo[k]++;
            end
        end else if (t >= ok[k] && req != 2'b00 && !ser_busy) begin
            if (req == 2'b11) g = 1 - ptr[k];
            else              g = (req == 2'b10) ? 1 : 0;
            e_start[k] = 1;
            e_ack[k]   = (g == 1) ? 2'b10 : 2'b01;
            e_gid[k]   = g[0];
            e_word[k]  = 16'h3000 | 16'(g << 15) | 16'(g ? data1 : data0);
            act[k]     = 1;
            st[k]      = t + 1;
            ptr[k]     = g;
            n_frames[k]++;
        end
        e_busy[k] = act[k] || (t + 1 < ok[k]);
    endtask

    task automatic check_all();
        chk("u0.ser_start", 32'(st0),   32'(e_start[0]));
        chk("u0.ack",       32'(ack0),  32'(e_ack[0]));
        chk("u0.ser_word",  32'(word0), 32'(e_word[0]));
        chk("u0.grant_id",  32'(gid0),  32'(e_gid[0]));
        chk("u0.busy",      32'(busy0), 32'(e_busy[0]));
        chk("u0.err",       32'(err0),  32'(e_err[0]));
        chk("u1.ser_start", 32'(st1),   32'(e_start[1]));
        chk("u1.ack",       32'(ack1),  32'(e_ack[1]));
        chk("u1.ser_word",  32'(word1), 32'(e_word[1]));
        chk("u1.grant_id",  32'(gid1),  32'(e_gid[1]));
        chk("u1.busy",      32'(busy1), 32'(e_busy[1]));
        chk("u1.err",       32'(err1),  32'(e_err[1]));
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; data0 = '0; data1 = '0;
        ser_busy = 1'b0; ser_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_frames[k] = 0; n_tmo[k] = 0;
        end

        // reset state
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, k ? 5 : 64, k ? 0 : 2);
        #1;
        chk("rst.ack0",  32'(ack0),  32'h0);
        chk("rst.start0", 32'(st0),  32'h0);
        chk("rst.word0", 32'(word0), 32'h0);
        chk("rst.gid0",  32'(gid0),  32'h0);
        chk("rst.busy0", 32'(busy0), 32'h0);
        chk("rst.err0",  32'(err0),  32'h0);
        chk("rst.word1", 32'(word1), 32'h0);
        chk("rst.busy1", 32'(busy1), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            // reset pulses, kept away from the long no-done window
            rst = !((c < 400 || c > 700) && $urandom_range(0, 249) == 0);
            // tie-heavy request mix; withdrawals before ack are legal
            case ($urandom_range(0, 3))
                0:       req = 2'b01;
                1:       req = 2'b10;
                default: req = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b11;
            endcase
            data0 = 12'($urandom);
            data1 = 12'($urandom);
            if (c >= 300 && c < 320)      ser_busy = 1'b1;
            else                          ser_busy = ($urandom_range(0, 5) == 0);
            if (c >= 400 && c < 600)      ser_done = 1'b0;
            else                          ser_done = ($urandom_range(0, 5) == 0);

            @(posedge clk);
            model_step(0, 64, 2);
            model_step(1, 5, 0);
            t++;
            #1;
            check_all();
        end

        // the random run must actually have exercised grants and timeouts
        chk("cov.u0_frames", 32'(n_frames[0] > 50), 32'h1);
        chk("cov.u0_tmo",    32'(n_tmo[0] > 0),     32'h1);
        chk("cov.u1_tmo",    32'(n_tmo[1] > 0),     32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_write_arbiter.md
Name: dac_write_arbiter

Overview:
Round-robin scheduler that shares the single DAC SPI serializer between the two DAC channels (A/B) of the synthesizer output stage. Each voice/channel source presents a 12-bit sample with a request. The block picks a winner, formats the 16-bit DAC command word and starts the serializer. It then waits for completion, enforces a minimum inter-frame gap, and recovers from a hung serializer with a timeout.

Parameters:
DATA_W, 12, sample width; the command word is always 16 bits.
MIN_GAP, 2, idle cycles enforced between serializer done and the next arbitration (0 allowed).
TIMEOUT, 64, cycles to wait for ser_done before aborting (must be ≥1).
BUF_BIT, 0, value placed in command bit 14 (VREF buffer).
GAIN_N_BIT, 1, value placed in command bit 13 (gain, active-low).
SHDN_N_BIT, 1, value placed in command bit 12 (output enable, active-low shutdown).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-low reset.
req  in  2  req[k] high = channel k has a sample pending; the source holds req and its data until ack[k].
data0  in  DATA_W  channel A sample.
data1  in  DATA_W  channel B sample.
ack  out  2  one-cycle pulse on the granted channel, coincident with ser_start.
ser_start  out  1  one-cycle pulse that launches a serializer frame.
ser_word  out  16  command word; stable from ser_start until the block leaves WAIT.
ser_busy  in  1  serializer busy; a new frame starts only when this is low.
ser_done  in  1  one-cycle pulse at the end of a serializer frame.
grant_id  out  1  channel of the current or last frame (0=A, 1=B).
busy  out  1  high whenever state ≠ IDLE.
err  out  1  sticky timeout flag.

Behaviour:
- Reset: on a clock edge with rst=0:
  - state=IDLE.
  - ack=0, ser_start=0, ser_word=0, grant_id=0, err=0.
  - Round-robin pointer set so channel A wins the first tie.
  - Gap and timeout counters are cleared.
  - This applies in any state. An in-flight frame is abandoned: no ack and no restart.
- States: IDLE, WAIT, GAP.
- IDLE:
  - Arbitration happens when req≠0 and ser_busy=0.
  - Winner: with one requester, that requester. With both, the channel not granted last.
  - At the end of the IDLE cycle the block registers:
    - ser_start=1 and ack[g]=1;
    - grant_id=g;
    - ser_word = {g, BUF_BIT, GAIN_N_BIT, SHDN_N_BIT, data_g}, with data sampled in that IDLE cycle.
  - It then moves to WAIT and updates the pointer.
  - If ser_busy=1, it stays in IDLE and no ack is issued.
- Latency: req sampled high in IDLE cycle i → ser_start and ack high in cycle i+1, for exactly one cycle.
- WAIT:
  - ser_done is honoured from the cycle after ser_start onward.
  - On ser_done=1: go to GAP, or to IDLE if MIN_GAP=0.
  - The timeout counter increments each WAIT cycle. If it reaches TIMEOUT without ser_done: err←1, go to GAP (or IDLE if MIN_GAP=0).
  - ser_done arriving in the same cycle as the timeout counts as done: err is unchanged.
- GAP:
  - Occupies exactly MIN_GAP cycles, counting down, then goes to IDLE.
  - req is ignored during GAP.
  - If ser_done is high in cycle c, the earliest next ser_start is cycle c+MIN_GAP+2.
- ser_done outside WAIT is ignored.
- err stays set until reset; it never blocks operation.
- Requests withdrawn before ack are legal: arbitration uses only the current cycle's req.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Single request: rst pulse, then req=01, data0=0x123 → ser_start and ack=01 one cycle later; ser_word=0x3123; grant_id=0; busy high until the gap ends.
- Tie: req=11, data0=0x0AA, data1=0xFFF, both held until ack → first frame 0x30AA with ack=01; after ser_done and gap, 0xBFFF with ack=10; a third frame (req0 re-asserted) returns to channel A.
- Serializer busy: req=10 while ser_busy=1 for 20 cycles → no ser_start or ack; start occurs the cycle after ser_busy falls.
- Gap timing: MIN_GAP=2, ser_done high in cycle c, req held → next ser_start exactly at cycle c+4. With MIN_GAP=0 → cycle c+2.
- Timeout: ser_done never asserted → err=1 after TIMEOUT=64 WAIT cycles; block returns to IDLE and services the next request normally, with err still 1.
- Reset mid-frame: rst=0 for one edge while in WAIT → next cycle all outputs 0, err=0, busy=0. A late ser_done is ignored. A new req=11 is granted to channel A first.
